// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 streaming convolution: FSM encoding and default sizing.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_IMG_W     = 224;
    localparam int DEF_CH        = 4;
    localparam int DEF_DW        = 9;
    localparam int DEF_WW        = 16;
    localparam int DEF_ACC_W     = 36;
    localparam int DEF_OUT_SHIFT = 4;
    localparam int DEF_OUT_W     = 8;

endpackage

// File: rtl/conv_window_buf.sv
// Single-channel line buffer for a padded raster stream, exposing the 3x3 window
// ending at the incoming sample (tap k = raster position, tap 0 = top-left).
module conv_window_buf
    import conv_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int DW    = DEF_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            shift,
    input  logic [DW-1:0]   sample,
    output logic [9*DW-1:0] window
);

    localparam int P     = IMG_W + 2;
    localparam int DEPTH = 2 * P + 3;
    // The incoming sample is window position 0, so only DEPTH-1 entries need storage.
    localparam int STORE = DEPTH - 1;

    logic [DW-1:0] taps [STORE];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < STORE; i++) taps[i] <= '0;
        end else if (shift) begin
            taps[0] <= sample;
            for (int i = 1; i < STORE; i++) taps[i] <= taps[i-1];
        end
    end

    for (genvar k = 0; k < 9; k++) begin : g_tap
        localparam int IDX = (2 - k / 3) * P + (2 - k % 3);
        if (IDX == 0) begin : g_live
            assign window[k*DW +: DW] = sample;
        end else begin : g_stored
            assign window[k*DW +: DW] = taps[IDX-1];
        end
    end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over CH zero-padded input channels with bias, optional
// ReLU and saturating pixel quantisation; one frame per start pulse.
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int IMG_W     = DEF_IMG_W,
    parameter int CH        = DEF_CH,
    parameter int DW        = DEF_DW,
    parameter int WW        = DEF_WW,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int OUT_SHIFT = DEF_OUT_SHIFT,
    parameter int OUT_W     = DEF_OUT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [$clog2(CH*9+1)-1:0]   cfg_addr,
    input  logic [WW-1:0]               cfg_data,
    input  logic                        relu_en,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CH*DW-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_W-1:0]            out_sum,
    output logic [OUT_W-1:0]            out_pix,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam int P  = IMG_W + 2;
    localparam int NW = CH * 9;
    localparam int AW = $clog2(NW + 1);
    localparam int RW = $clog2(P + 1);

    state_t state, state_nxt;

    logic [RW-1:0]          row, col;
    logic                   relu_q;
    logic signed [WW-1:0]   weights [NW];
    logic signed [WW-1:0]   bias;
    logic [9*DW-1:0]        win [CH];

    logic                   all_taken, accept, take, clear_buf, win_valid, last_win;
    logic signed [ACC_W-1:0] sum_raw, sum_act;
    logic [ACC_W-1:0]       shifted;
    logic [OUT_W-1:0]       pix;
    logic signed [DW-1:0]   s_tap;
    logic signed [WW-1:0]   w_tap;
    logic signed [DW+WW-1:0] prod;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (take && out_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign all_taken = (row == RW'(P));
    assign in_ready  = (state == RUN) && !all_taken && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;
    assign clear_buf = (state == IDLE) && start;
    assign win_valid = (row >= RW'(2)) && (col >= RW'(2));
    assign last_win  = (row == RW'(P - 1)) && (col == RW'(P - 1));

    // Padded raster position of the next sample to arrive.
    always_ff @(posedge clk) begin
        if (rst) begin
            row    <= '0;
            col    <= '0;
            relu_q <= 1'b0;
        end else if (clear_buf) begin
            row    <= '0;
            col    <= '0;
            relu_q <= relu_en;
        end else if (accept) begin
            if (col == RW'(P - 1)) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NW; i++) weights[i] <= '0;
            bias <= '0;
        end else if (cfg_we && state == IDLE) begin
            for (int i = 0; i < NW; i++)
                if (cfg_addr == AW'(i)) weights[i] <= cfg_data;
            if (cfg_addr == AW'(NW)) bias <= cfg_data;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        conv_window_buf #(
            .IMG_W (IMG_W),
            .DW    (DW)
        ) u_buf (
            .clk    (clk),
            .rst    (rst),
            .clear  (clear_buf),
            .shift  (accept),
            .sample (in_data[g*DW +: DW]),
            .window (win[g])
        );
    end

    // The window already includes the sample being accepted, giving one cycle of latency.
    always_comb begin
        s_tap   = '0;
        w_tap   = '0;
        prod    = '0;
        sum_raw = ACC_W'(bias);
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < 9; k++) begin
                s_tap   = $signed(win[c][k*DW +: DW]);
                w_tap   = weights[c*9 + k];
                prod    = (DW+WW)'(s_tap) * (DW+WW)'(w_tap);
                sum_raw = sum_raw + ACC_W'(prod);
            end
        end
    end

    always_comb begin
        sum_act = (relu_q && sum_raw[ACC_W-1]) ? '0 : sum_raw;
        shifted = '0;
        pix     = '0;
        if (!sum_act[ACC_W-1]) begin
            shifted = sum_act >> OUT_SHIFT;
            pix     = (|shifted[ACC_W-1:OUT_W]) ? '1 : shifted[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_pix   <= '0;
            out_last  <= 1'b0;
        end else if (accept && win_valid) begin
            out_valid <= 1'b1;
            out_sum   <= sum_act;
            out_pix   <= pix;
            out_last  <= last_win;
        end else if (take) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule
